// File: rtl/gate_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gate_sweep_ctrl
// Description : Truth-table sweep sequencer for an N-input combinational gate.
//               Drives every input vector, holds it for a settle window,
//               samples the gate output against an expected truth table and
//               reports per-vector results plus a pass/fail summary.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_sweep_ctrl #(
    parameter int                       N_IN   = 3,
    parameter int                       SETTLE = 2,
    parameter logic [(1 << N_IN) - 1:0] EXPECT = 8'h7F
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [N_IN-1:0] gate_in,
    input  logic            gate_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   fail_cnt,
    output logic [N_IN-1:0] first_fail_vec,
    output logic            sample_valid,
    output logic [N_IN-1:0] sample_vec,
    output logic            sample_ok
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SETTLE = 2'd1;
    localparam logic [1:0] c_ST_SAMPLE = 2'd2;
    localparam logic [1:0] c_ST_DONE   = 2'd3;

    // Settle counter reaches this value in the last SETTLE-state cycle.
    localparam logic [7:0]      c_CNT_LAST = 8'(SETTLE - 1);
    localparam logic [N_IN-1:0] c_LAST_VEC = {N_IN{1'b1}};

    logic [1:0]      state_q,          state_d;
    logic [7:0]      cnt_q,            cnt_d;
    logic [N_IN-1:0] gate_in_q,        gate_in_d;
    logic            busy_q,           busy_d;
    logic            done_q,           done_d;
    logic            pass_q,           pass_d;
    logic [N_IN:0]   fail_cnt_q,       fail_cnt_d;
    logic [N_IN-1:0] first_fail_vec_q, first_fail_vec_d;
    logic            sample_valid_q,   sample_valid_d;
    logic [N_IN-1:0] sample_vec_q,     sample_vec_d;
    logic            sample_ok_q,      sample_ok_d;
    logic            w_match;

    // Compare gate output with the expected bit; an unknown output takes the
    // else branch and so counts as a mismatch.
    always_comb begin
        w_match = 1'b0;
        if (gate_out == EXPECT[gate_in_q]) begin
            w_match = 1'b1;
        end
    end

    // Next-state and next-output logic for the sweep sequencer.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        gate_in_d        = gate_in_q;
        fail_cnt_d       = fail_cnt_q;
        first_fail_vec_d = first_fail_vec_q;
        pass_d           = pass_q;
        sample_valid_d   = 1'b0;
        sample_vec_d     = sample_vec_q;
        sample_ok_d      = sample_ok_q;

        case (state_q)
            c_ST_IDLE: begin
                gate_in_d = '0;
                if (start) begin
                    state_d          = c_ST_SETTLE;
                    cnt_d            = 8'd0;
                    fail_cnt_d       = '0;
                    first_fail_vec_d = '0;
                    pass_d           = 1'b0;
                end
            end
            c_ST_SETTLE: begin
                if (cnt_q == c_CNT_LAST) begin
                    state_d = c_ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            c_ST_SAMPLE: begin
                sample_valid_d = 1'b1;
                sample_vec_d   = gate_in_q;
                sample_ok_d    = w_match;
                if (!w_match) begin
                    fail_cnt_d = fail_cnt_q + (N_IN + 1)'(1);
                    if (fail_cnt_q == '0) begin
                        first_fail_vec_d = gate_in_q;
                    end
                end
                if (gate_in_q == c_LAST_VEC) begin
                    // pass reflects the count including this final vector.
                    state_d = c_ST_DONE;
                    pass_d  = (fail_cnt_d == '0);
                end else begin
                    state_d   = c_ST_SETTLE;
                    gate_in_d = gate_in_q + N_IN'(1);
                    cnt_d     = 8'd0;
                end
            end
            default: begin
                state_d   = c_ST_IDLE;
                gate_in_d = '0;
            end
        endcase

        // busy and done are registered Moore decodes of the next state.
        busy_d = (state_d != c_ST_IDLE);
        done_d = (state_d == c_ST_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= c_ST_IDLE;
            cnt_q            <= 8'd0;
            gate_in_q        <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            fail_cnt_q       <= '0;
            first_fail_vec_q <= '0;
            sample_valid_q   <= 1'b0;
            sample_vec_q     <= '0;
            sample_ok_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            gate_in_q        <= gate_in_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            pass_q           <= pass_d;
            fail_cnt_q       <= fail_cnt_d;
            first_fail_vec_q <= first_fail_vec_d;
            sample_valid_q   <= sample_valid_d;
            sample_vec_q     <= sample_vec_d;
            sample_ok_q      <= sample_ok_d;
        end
    end

    assign gate_in        = gate_in_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign fail_cnt       = fail_cnt_q;
    assign first_fail_vec = first_fail_vec_q;
    assign sample_valid   = sample_valid_q;
    assign sample_vec     = sample_vec_q;
    assign sample_ok      = sample_ok_q;

endmodule
`default_nettype wire

// File: tb/tb_gate_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_sweep_ctrl
// Description : Self-checking bench for gate_sweep_ctrl. Two instances share
//               clock, reset and start: one expects NAND3, one XOR3. Both see
//               the same behavioural gate, a truth table held in tt.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_sweep_ctrl;

    localparam logic [7:0] c_EXP0 = 8'h7F;
    localparam logic [7:0] c_EXP1 = 8'h96;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] tt;

    logic [2:0] gi   [2];
    logic       go   [2];
    logic       busy [2];
    logic       done [2];
    logic       pass [2];
    logic [3:0] fcnt [2];
    logic [2:0] ffv  [2];
    logic       sv   [2];
    logic [2:0] svec [2];
    logic       sok  [2];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign go[0] = tt[gi[0]];
    assign go[1] = tt[gi[1]];

    gate_sweep_ctrl #(.N_IN(3), .SETTLE(2), .EXPECT(c_EXP0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .gate_in(gi[0]), .gate_out(go[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .fail_cnt(fcnt[0]),
        .first_fail_vec(ffv[0]), .sample_valid(sv[0]), .sample_vec(svec[0]),
        .sample_ok(sok[0])
    );

    gate_sweep_ctrl #(.N_IN(3), .SETTLE(2), .EXPECT(c_EXP1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .gate_in(gi[1]), .gate_out(go[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .fail_cnt(fcnt[1]),
        .first_fail_vec(ffv[1]), .sample_valid(sv[1]), .sample_vec(svec[1]),
        .sample_ok(sok[1])
    );

    task automatic chk(input string tag, input int d, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
        end
    endtask

    // All outputs of instance d at their reset values.
    task automatic chk_idle_zero(input int d);
        chk("rst_gate_in", d, 32'(gi[d]), 32'd0);
        chk("rst_busy",    d, 32'(busy[d]), 32'd0);
        chk("rst_done",    d, 32'(done[d]), 32'd0);
        chk("rst_pass",    d, 32'(pass[d]), 32'd0);
        chk("rst_fail_cnt", d, 32'(fcnt[d]), 32'd0);
        chk("rst_first_fail", d, 32'(ffv[d]), 32'd0);
        chk("rst_sample_valid", d, 32'(sv[d]), 32'd0);
        chk("rst_sample_vec", d, 32'(svec[d]), 32'd0);
        chk("rst_sample_ok", d, 32'(sok[d]), 32'd0);
    endtask

    // Reference model: t cycles after the accepting edge, each vector v is held
    // for 3 cycles and its compare result appears at t = 3*(v+1).
    task automatic chk_model(input int d, input int t, input logic [7:0] e);
        int         nf;
        int         first;
        int         vec;
        logic       exp_sv;
        nf    = 0;
        first = 0;
        for (int v = 0; v < 8; v++) begin
            if (3 * (v + 1) <= t && tt[v] != e[v]) begin
                if (nf == 0) first = v;
                nf++;
            end
        end
        exp_sv = (t >= 3) && (t <= 24) && (t % 3 == 0);
        chk("gate_in", d, 32'(gi[d]), (t < 24) ? 32'(t / 3) : ((t == 24) ? 32'd7 : 32'd0));
        chk("busy", d, 32'(busy[d]), 32'(t <= 24));
        chk("done", d, 32'(done[d]), 32'(t == 24));
        chk("sample_valid", d, 32'(sv[d]), 32'(exp_sv));
        if (exp_sv) begin
            vec = t / 3 - 1;
            chk("sample_vec", d, 32'(svec[d]), 32'(vec));
            chk("sample_ok", d, 32'(sok[d]), 32'(tt[vec] == e[vec]));
        end
        chk("fail_cnt", d, 32'(fcnt[d]), 32'(nf));
        chk("first_fail_vec", d, 32'(ffv[d]), 32'(first));
        chk("pass", d, 32'(pass[d]), 32'((t >= 24) && (nf == 0)));
    endtask

    // One sweep with gate truth table g. extra re-pulses start inside the
    // sweep; abort_t >= 0 asserts rst after that many cycles.
    task automatic sweep(input logic [7:0] g, input bit extra, input int abort_t);
        tt    = g;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int t = 0; t <= 25; t++) begin
            if (t == abort_t) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                chk_idle_zero(0);
                chk_idle_zero(1);
                for (int c = 0; c < 26; c++) begin
                    @(posedge clk); #1;
                    chk("abort_no_done", 0, 32'(done[0]), 32'd0);
                    chk("abort_no_busy", 0, 32'(busy[0]), 32'd0);
                end
                return;
            end
            chk_model(0, t, c_EXP0);
            chk_model(1, t, c_EXP1);
            start = extra && (t == 4 || t == 23);
            if (t < 25) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        tt    = 8'h7F;
        repeat (3) @(posedge clk);
        #1;
        chk_idle_zero(0);
        chk_idle_zero(1);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            chk("idle_busy", 0, 32'(busy[0]), 32'd0);
            chk("idle_done", 0, 32'(done[0]), 32'd0);
        end

        sweep(8'h7F, 1'b0, -1);   // correct NAND3
        sweep(8'h00, 1'b0, -1);   // stuck at 0, back-to-back start
        sweep(8'h7F, 1'b1, -1);   // ignored re-starts, counters cleared
        sweep(8'h7F, 1'b0, 13);   // reset while gate_in = 4
        sweep(8'h96, 1'b0, -1);   // correct XOR3
        sweep(8'hFF, 1'b0, -1);   // stuck at 1
        for (int r = 0; r < 4; r++) begin
            sweep(8'($urandom), 1'b0, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
